uart_message_sequencer: RTL and testbench

Sequences periodic transmission of a fixed ASCII message through the UART transmitter. An internal phase-accumulator tick (default 2 Hz at 48 MHz) starts each message. The block then streams MSG_LEN characters from a parameter ROM to uart_tx over a valid/ready handshake. It sits between the system clock domain and uart_tx, and replaces free-running character indexing with a handshake-driven index.

---
 rtl/uart_pkg.sv | 16 +
 rtl/message_tick_gen.sv | 39 +++
 rtl/uart_message_sequencer.sv | 115 +++++++++++
 tb/tb_uart_message_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and rate constants for the UART message path
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // 48 MHz system clock, 2 Hz message tick: 48e6 * 2932031 / 2^46 ~= 2.0 Hz
    localparam int unsigned     ACC_W_DEFAULT    = 46;
    localparam longint unsigned TICK_INC_DEFAULT = 64'd2932031;

    localparam int unsigned     UART_BAUD        = 115200;

endpackage

// File: rtl/message_tick_gen.sv
// rtl/message_tick_gen.sv - phase-accumulator tick generator
//
// Purpose: emits a registered one-cycle tick whenever the phase accumulator
//          wraps; rate = f_clk * TICK_INC / 2^ACC_W. Also usable as a baud strobe.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high reset
//   enable  in  run the accumulator; while low, accumulator and tick stay at 0
//   tick    out one-cycle pulse on accumulator carry-out
module message_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned     ACC_W    = ACC_W_DEFAULT,
    parameter longint unsigned TICK_INC = TICK_INC_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // Carry of the (ACC_W+1)-bit sum is the tick
    assign sum = {1'b0, acc} + (ACC_W+1)'(TICK_INC);

    // Holding at zero while disabled makes the first tick land one full
    // period after enable rises.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            acc  <= '0;
            tick <= 1'b0;
        end else begin
            {tick, acc} <= sum;
        end
    end

endmodule

// File: rtl/uart_message_sequencer.sv
// rtl/uart_message_sequencer.sv - periodic fixed-message streamer toward uart_tx
//
// Purpose: on each tick (while enabled) streams MSG_LEN characters of MSG to
//          uart_tx over a valid/ready handshake; char 0 is the MSB byte of MSG.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous, active-high reset
//   enable      in  permits new messages to start
//   tx_ready    in  uart_tx accepts a byte this cycle
//   tx_valid    out tx_data valid, held until accepted
//   tx_data     out current character
//   char_index  out index of the character being offered
//   busy        out message in progress
//   msg_done    out one-cycle pulse after the last character is accepted
//   overrun     out one-cycle pulse when a tick arrives while busy
module uart_message_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned             ACC_W    = ACC_W_DEFAULT,
    parameter longint unsigned         TICK_INC = TICK_INC_DEFAULT,
    parameter int unsigned             MSG_LEN  = 16,
    parameter logic [8*MSG_LEN-1:0]    MSG      = "Hello World!\r\n  "
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic [3:0] char_index,
    output logic       busy,
    output logic       msg_done,
    output logic       overrun
);

    localparam logic [3:0] LAST_INDEX = 4'(MSG_LEN - 1);

    seq_state_t state;
    logic       tick;
    logic [3:0] next_index;

    message_tick_gen #(
        .ACC_W    (ACC_W),
        .TICK_INC (TICK_INC)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // Combinational ROM: constant part-selects avoid out-of-range slicing
    function automatic logic [7:0] rom_byte(input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < int'(MSG_LEN); i++) begin
            if (idx == 4'(i)) b = MSG[8*(int'(MSG_LEN)-1-i) +: 8];
        end
        return b;
    endfunction

    assign next_index = char_index + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            char_index <= 4'd0;
            busy       <= 1'b0;
            msg_done   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            // Ticks are never queued; one arriving in SEND or DONE is dropped
            overrun  <= tick && (state != IDLE);

            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        state      <= SEND;
                        char_index <= 4'd0;
                        tx_data    <= rom_byte(4'd0);
                        tx_valid   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SEND: begin
                    // tx_valid is always high here, so tx_ready alone means accepted
                    if (tx_ready) begin
                        if (char_index == LAST_INDEX) begin
                            state      <= DONE;
                            tx_valid   <= 1'b0;
                            char_index <= 4'd0;
                            msg_done   <= 1'b1;
                        end else begin
                            char_index <= next_index;
                            tx_data    <= rom_byte(next_index);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_message_sequencer.sv
// tb/tb_uart_message_sequencer.sv - self-checking bench for uart_message_sequencer
module tb_uart_message_sequencer;

    localparam int ACC_W    = 8;
    localparam int TICK_INC = 64;

    logic       clk = 1'b0;
    logic       reset, enable, tx_ready;
    logic       tx_valid0, busy0, msg_done0, overrun0;
    logic [7:0] tx_data0;
    logic [3:0] char_index0;
    logic       tx_valid1, busy1, msg_done1, overrun1;
    logic [7:0] tx_data1;
    logic [3:0] char_index1;

    int errors = 0;
    int checks = 0;

    uart_message_sequencer #(
        .ACC_W(ACC_W), .TICK_INC(TICK_INC), .MSG_LEN(3), .MSG("ABC")
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .tx_ready(tx_ready),
        .tx_valid(tx_valid0), .tx_data(tx_data0), .char_index(char_index0),
        .busy(busy0), .msg_done(msg_done0), .overrun(overrun0)
    );

    uart_message_sequencer #(
        .ACC_W(ACC_W), .TICK_INC(TICK_INC), .MSG_LEN(1), .MSG("Z")
    ) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .tx_ready(tx_ready),
        .tx_valid(tx_valid1), .tx_data(tx_data1), .char_index(char_index1),
        .busy(busy1), .msg_done(msg_done1), .overrun(overrun1)
    );

    always #5 clk = ~clk;

    // Reference model: phase as integer arithmetic, message progress as a
    // position (-1 idle, 0..len-1 offering char, len = done cycle).
    int  acc_m;
    bit  tick_m;
    int  pos [2];
    bit  ovr [2];
    int  len [2] = '{3, 1};
    logic [7:0] sent0 [$];
    logic [7:0] sent1 [$];

    function automatic logic [7:0] msg_byte(int k, int p);
        if (k == 1) return 8'h5A;
        case (p)
            0:       return 8'h41;
            1:       return 8'h42;
            default: return 8'h43;
        endcase
    endfunction

    function automatic logic [15:0] exp_vec(int k);
        logic v;
        v = (pos[k] >= 0) && (pos[k] < len[k]);
        return {v, v ? msg_byte(k, pos[k]) : 8'h00, v ? 4'(pos[k]) : 4'h0,
                pos[k] >= 0, pos[k] == len[k], ovr[k]};
    endfunction

    function automatic logic [15:0] obs_vec(int k);
        if (k == 0)
            return {tx_valid0, tx_valid0 ? tx_data0 : 8'h00, char_index0, busy0, msg_done0, overrun0};
        return {tx_valid1, tx_valid1 ? tx_data1 : 8'h00, char_index1, busy1, msg_done1, overrun1};
    endfunction

    function automatic void model_edge(bit en, bit rdy, bit rst);
        int s;
        if (rst) begin
            acc_m  = 0;
            tick_m = 0;
            for (int k = 0; k < 2; k++) begin pos[k] = -1; ovr[k] = 0; end
            return;
        end
        for (int k = 0; k < 2; k++) begin
            ovr[k] = tick_m && (pos[k] >= 0);
            if (pos[k] == -1) begin
                if (tick_m && en) pos[k] = 0;
            end else if (pos[k] == len[k]) begin
                pos[k] = -1;
            end else if (rdy) begin
                pos[k] = pos[k] + 1;
            end
        end
        if (!en) begin
            acc_m  = 0;
            tick_m = 0;
        end else begin
            s      = acc_m + TICK_INC;
            tick_m = (s >= (1 << ACC_W));
            acc_m  = s % (1 << ACC_W);
        end
    endfunction

    task automatic step(input bit en, input bit rdy, input bit rst);
        enable   = en;
        tx_ready = rdy;
        reset    = rst;
        if (tx_valid0 && rdy && !rst) sent0.push_back(tx_data0);
        if (tx_valid1 && rdy && !rst) sent1.push_back(tx_data1);
        @(posedge clk);
        model_edge(en, rdy, rst);
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 1);
        sent0.delete();
        sent1.delete();
    endtask

    task automatic test_reset();
        do_reset();
        step(0, 0, 1);
        checks++;
        if ({tx_valid0, tx_data0, char_index0, busy0, msg_done0, overrun0} !== 16'h0) begin
            errors++;
            $display("FAIL reset_dut0 got=%h exp=0000", {tx_valid0, tx_data0, char_index0, busy0, msg_done0, overrun0});
        end
        checks++;
        if ({tx_valid1, tx_data1, char_index1, busy1, msg_done1, overrun1} !== 16'h0) begin
            errors++;
            $display("FAIL reset_dut1 got=%h exp=0000", {tx_valid1, tx_data1, char_index1, busy1, msg_done1, overrun1});
        end
        checks++;
        if (dut.u_tick.acc !== 8'h00 || dut.u_tick.tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_acc got=%h/%b exp=00/0", dut.u_tick.acc, dut.u_tick.tick);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            step(1, 1, 0);
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL basic c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
            end
            if (c >= 5 && c <= 7) begin
                checks++;
                if (tx_valid0 !== 1'b1 || tx_data0 !== 8'(8'h40 + c - 4) || char_index0 !== 4'(c - 5)) begin
                    errors++;
                    $display("FAIL basic_char c=%0d got=%b/%h/%0d exp=1/%h/%0d",
                             c, tx_valid0, tx_data0, char_index0, 8'(8'h40 + c - 4), c - 5);
                end
            end
            if (c == 8) begin
                checks++;
                if (msg_done0 !== 1'b1 || busy0 !== 1'b1 || tx_valid0 !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_done got=%b/%b/%b exp=1/1/0", msg_done0, busy0, tx_valid0);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit seen;
        do_reset();
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step(1, 0, 0);
            seen = tx_valid0;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_start got=tx_valid 0 exp=1 within 10 cycles");
        end
        for (int c = 0; c < 10; c++) begin
            step(1, 0, 0);
            checks++;
            if (obs_vec(0) !== exp_vec(0) || tx_data0 !== 8'h41 || char_index0 !== 4'd0) begin
                errors++;
                $display("FAIL stall_hold c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
            end
        end
        sent0.delete();
        for (int c = 0; c < 6; c++) begin
            step(1, 1, 0);
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL stall_release c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
            end
        end
        checks++;
        if (sent0.size() < 3 || sent0[0] !== 8'h41 || sent0[1] !== 8'h42 || sent0[2] !== 8'h43) begin
            errors++;
            $display("FAIL stall_seq got_n=%0d exp=ABC", sent0.size());
        end
    endtask

    task automatic test_overrun();
        int n_ovr, n_done;
        bit seen;
        do_reset();
        n_ovr = 0; n_done = 0; seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step(1, 0, 0);
            seen = tx_valid0;
        end
        for (int c = 0; c < 4; c++) begin
            step(1, 0, 0);
            n_ovr += overrun0;
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL overrun_stall c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
            end
        end
        for (int c = 0; c < 12; c++) begin
            step(0, 1, 0);
            n_ovr  += overrun0;
            n_done += msg_done0;
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL overrun_release c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
            end
        end
        checks++;
        if (n_ovr != 1 || n_done != 1 || sent0.size() != 3) begin
            errors++;
            $display("FAIL overrun_count got ovr=%0d done=%0d bytes=%0d exp 1/1/3", n_ovr, n_done, sent0.size());
        end
    endtask

    task automatic test_enable_drop();
        int n_done;
        bit seen;
        do_reset();
        n_done = 0; seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            step(1, 1, 0);
            seen = tx_valid0 && (char_index0 == 4'd1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL endrop_reach got=no char_index 1 exp=reached within 12 cycles");
        end
        for (int c = 0; c < 12; c++) begin
            step(0, 1, 0);
            n_done += msg_done0;
            checks++;
            if (obs_vec(0) !== exp_vec(0) || dut.u_tick.acc !== 8'h00) begin
                errors++;
                $display("FAIL endrop c=%0d got=%h acc=%h exp=%h acc=00", c, obs_vec(0), dut.u_tick.acc, exp_vec(0));
            end
        end
        checks++;
        if (n_done != 1 || sent0.size() != 3 || sent0[1] !== 8'h42 || sent0[2] !== 8'h43) begin
            errors++;
            $display("FAIL endrop_seq got done=%0d bytes=%0d exp 1/3 ABC", n_done, sent0.size());
        end
    endtask

    task automatic test_reset_mid();
        int first;
        bit seen;
        do_reset();
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            step(1, 0, 0);
            seen = tx_valid0;
        end
        step(1, 1, 0);
        checks++;
        if (tx_valid0 !== 1'b1 || char_index0 !== 4'd1) begin
            errors++;
            $display("FAIL rstmid_pre got=%b/%0d exp=1/1", tx_valid0, char_index0);
        end
        step(1, 0, 1);
        checks++;
        if (tx_valid0 !== 1'b0 || busy0 !== 1'b0 || char_index0 !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_post got=%b/%b/%0d exp=0/0/0", tx_valid0, busy0, char_index0);
        end
        first = 0;
        for (int c = 1; c <= 8; c++) begin
            step(1, 0, 0);
            if (first == 0 && tx_valid0) first = c;
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL rstmid_run c=%0d got=%h exp=%h", c, obs_vec(0), exp_vec(0));
            end
        end
        checks++;
        if (first != 5 || tx_data0 !== 8'h41) begin
            errors++;
            $display("FAIL rstmid_restart got cycle=%0d data=%h exp cycle=5 data=41", first, tx_data0);
        end
    endtask

    task automatic test_len1();
        int n_done;
        do_reset();
        n_done = 0;
        for (int c = 1; c <= 24; c++) begin
            step(1, c[0], 0);
            n_done += msg_done1;
            checks++;
            if (obs_vec(1) !== exp_vec(1)) begin
                errors++;
                $display("FAIL len1 c=%0d got=%h exp=%h", c, obs_vec(1), exp_vec(1));
            end
        end
        checks++;
        if (n_done < 2 || sent1.size() != n_done) begin
            errors++;
            $display("FAIL len1_count got done=%0d bytes=%0d exp equal and >=2", n_done, sent1.size());
        end
        foreach (sent1[i]) begin
            checks++;
            if (sent1[i] !== 8'h5A) begin
                errors++;
                $display("FAIL len1_byte i=%0d got=%h exp=5a", i, sent1[i]);
            end
        end
    endtask

    task automatic test_random();
        bit en, rdy, rst;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom % 97) == 0;
            en  = ($urandom % 8) != 0;
            rdy = $urandom % 2;
            step(en, rdy, rst);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random dut%0d c=%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        tx_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin pos[k] = -1; ovr[k] = 0; end
        acc_m  = 0;
        tick_m = 0;
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_enable_drop();
        test_reset_mid();
        test_len1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
